// File: rtl/push_button_bounce_emitter_if.sv
// rtl/push_button_bounce_emitter_if.sv - command handshake between a command source and the bounce emitter
interface push_button_bounce_emitter_if #(
    parameter int NUM_BUTTONS = 4
);
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

    logic             CMD_VALID_I;
    logic             CMD_READY_O;
    logic [IDX_W-1:0] CMD_BUTTON_I;
    logic             CMD_PRESS_I;

    // command source side
    modport master (
        output CMD_VALID_I,
        output CMD_BUTTON_I,
        output CMD_PRESS_I,
        input  CMD_READY_O
    );

    // emitter side
    modport slave (
        input  CMD_VALID_I,
        input  CMD_BUTTON_I,
        input  CMD_PRESS_I,
        output CMD_READY_O
    );
endinterface

// File: rtl/push_button_bounce_emitter.sv
// rtl/push_button_bounce_emitter.sv - press/release commands to active-low bouncing button waveforms (BOUNCE_RANDOM_EN selects LFSR-gated bounce)
module push_button_bounce_emitter #(
    parameter int          NUM_BUTTONS   = 4,
    parameter int          BOUNCE_CYCLES = 50000,
    parameter int          TOGGLE_DIV    = 1250,
    parameter int          SETTLE_CYCLES = 500000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                         CLOCK_50_I,
    input  logic                         RESET_I,
    push_button_bounce_emitter_if.slave  cmd,
    output logic [NUM_BUTTONS-1:0]       PUSH_BUTTON_N_O,
    output logic                         BUSY_O,
    output logic                         DONE_O
);

    localparam int IDX_W = (NUM_BUTTONS > 1)   ? $clog2(NUM_BUTTONS)   : 1;
    localparam int BC_W  = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int TD_W  = (TOGGLE_DIV > 1)    ? $clog2(TOGGLE_DIV)    : 1;
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [BC_W-1:0] BC_RELOAD = BC_W'(BOUNCE_CYCLES - 1);
    localparam logic [TD_W-1:0] TD_RELOAD = TD_W'(TOGGLE_DIV - 1);
    localparam logic [SC_W-1:0] SC_RELOAD = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_target;
    logic [BC_W-1:0]        r_bounce_cnt;
    logic [TD_W-1:0]        r_tick_cnt;
    logic [SC_W-1:0]        r_settle_cnt;
    logic [15:0]            r_lfsr;
    logic [NUM_BUTTONS-1:0] r_btn_n;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_idx_ok;
    logic                   w_target;
    logic                   w_cur_level;
    logic                   w_noop;
    logic                   w_toggle_en;
    logic                   w_lfsr_fb;

    assign w_accept  = cmd.CMD_VALID_I & r_ready;
    assign w_idx_ok  = (32'(cmd.CMD_BUTTON_I) < NUM_BUTTONS);
    // press drives the line low, release drives it high
    assign w_target  = ~cmd.CMD_PRESS_I;
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

`ifdef BOUNCE_RANDOM_EN
    assign w_toggle_en = r_lfsr[0];
`else
    assign w_toggle_en = 1'b1;
`endif

    // current level of the addressed button; out-of-range indices never read the vector
    always_comb begin
        w_cur_level = 1'b1;
        if (w_idx_ok) begin
            w_cur_level = r_btn_n[cmd.CMD_BUTTON_I];
        end
    end

    assign w_noop = !w_idx_ok || (w_cur_level == w_target);

    // command FSM: accept in IDLE, toggle during BOUNCE, hold during SETTLE, pulse DONE on return
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_target     <= 1'b1;
            r_bounce_cnt <= '0;
            r_tick_cnt   <= '0;
            r_settle_cnt <= '0;
            r_lfsr       <= LFSR_SEED;
            r_btn_n      <= '1;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_noop) begin
                            // nothing to emit, but the source still sees completion
                            r_done <= 1'b1;
                        end else begin
                            r_idx        <= cmd.CMD_BUTTON_I;
                            r_target     <= w_target;
                            r_bounce_cnt <= BC_RELOAD;
                            r_tick_cnt   <= TD_RELOAD;
                            r_state      <= ST_BOUNCE;
                            r_ready      <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end
                end

                ST_BOUNCE: begin
                    if (r_bounce_cnt == '0) begin
                        // end of burst wins over any toggle due on the same edge
                        r_btn_n[r_idx] <= r_target;
                        r_settle_cnt   <= SC_RELOAD;
                        r_state        <= ST_SETTLE;
                    end else begin
                        r_bounce_cnt <= r_bounce_cnt - BC_W'(1);
                        if (r_tick_cnt == '0) begin
                            r_tick_cnt <= TD_RELOAD;
                            r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
                            if (w_toggle_en) begin
                                r_btn_n[r_idx] <= ~r_btn_n[r_idx];
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt - TD_W'(1);
                        end
                    end
                end

                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SC_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.CMD_READY_O = r_ready;
    assign PUSH_BUTTON_N_O = r_btn_n;
    assign BUSY_O          = r_busy;
    assign DONE_O          = r_done;

endmodule

// File: tb/tb_push_button_bounce_emitter.sv
// tb/tb_push_button_bounce_emitter.sv - directed self-checking bench for push_button_bounce_emitter
module tb_push_button_bounce_emitter;

    localparam int NB = 4;
    localparam int BC = 100;
    localparam int TD = 10;
    localparam int SC = 20;

    logic          CLOCK_50_I = 1'b0;
    logic          RESET_I    = 1'b1;
    logic [NB-1:0] PUSH_BUTTON_N_O;
    logic          BUSY_O;
    logic          DONE_O;

    int tests_run    = 0;
    int tests_failed = 0;

    push_button_bounce_emitter_if #(.NUM_BUTTONS(NB)) cmd_if ();

    push_button_bounce_emitter #(
        .NUM_BUTTONS   (NB),
        .BOUNCE_CYCLES (BC),
        .TOGGLE_DIV    (TD),
        .SETTLE_CYCLES (SC),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .RESET_I         (RESET_I),
        .cmd             (cmd_if.slave),
        .PUSH_BUTTON_N_O (PUSH_BUTTON_N_O),
        .BUSY_O          (BUSY_O),
        .DONE_O          (DONE_O)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // level of a bursting bit d cycles after acceptance (square-wave burst)
    function automatic logic burst_level(input logic start, input logic target, input int d);
        if (d >= BC) return target;
        return start ^ logic'((d / TD) % 2);
    endfunction

    // present a command in the cycle before the next edge, which becomes edge T
    task automatic issue(input int btn, input logic press);
        @(negedge CLOCK_50_I);
        cmd_if.CMD_VALID_I  = 1'b1;
        cmd_if.CMD_BUTTON_I = btn[1:0];
        cmd_if.CMD_PRESS_I  = press;
        @(posedge CLOCK_50_I);
        #1 cmd_if.CMD_VALID_I = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLOCK_50_I);
            if (DONE_O) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [NB-1:0] e;
        int            done_cnt;

        cmd_if.CMD_VALID_I  = 1'b0;
        cmd_if.CMD_BUTTON_I = '0;
        cmd_if.CMD_PRESS_I  = 1'b0;

        // 1: reset state
        repeat (3) @(posedge CLOCK_50_I);
        @(negedge CLOCK_50_I);
        check("rst_out",   32'(PUSH_BUTTON_N_O),   32'hF);
        check("rst_ready", 32'(cmd_if.CMD_READY_O), 32'd1);
        check("rst_busy",  32'(BUSY_O),            32'd0);
        check("rst_done",  32'(DONE_O),            32'd0);
        RESET_I = 1'b0;
        @(negedge CLOCK_50_I);
        check("post_rst_out", 32'(PUSH_BUTTON_N_O), 32'hF);

        // 2: press button 2, trace every cycle of the command
        issue(2, 1'b1);
        for (int c = 0; c <= BC + SC + 1; c++) begin
            @(negedge CLOCK_50_I);
            e    = 4'hF;
            e[2] = burst_level(1'b1, 1'b0, c);
            check($sformatf("p2_out_c%0d", c),  32'(PUSH_BUTTON_N_O),    32'(e));
            check($sformatf("p2_done_c%0d", c), 32'(DONE_O),             32'(c == BC + SC));
            check($sformatf("p2_busy_c%0d", c), 32'(BUSY_O),             32'(c < BC + SC));
            check($sformatf("p2_rdy_c%0d", c),  32'(cmd_if.CMD_READY_O), 32'(c >= BC + SC));
        end

        // 3: press button 2 again: no-op with a single DONE cycle
        issue(2, 1'b1);
        @(negedge CLOCK_50_I);
        check("noop_done_T",  32'(DONE_O),          32'd1);
        check("noop_busy_T",  32'(BUSY_O),          32'd0);
        check("noop_out_T",   32'(PUSH_BUTTON_N_O), 32'hB);
        @(negedge CLOCK_50_I);
        check("noop_done_T1", 32'(DONE_O),          32'd0);
        check("noop_out_T1",  32'(PUSH_BUTTON_N_O), 32'hB);
        check("noop_rdy_T1",  32'(cmd_if.CMD_READY_O), 32'd1);

        // prepare: press button 1 so that releasing it later is a real burst
        issue(1, 1'b1);
        wait_done("prep_done");
        check("prep_out", 32'(PUSH_BUTTON_N_O), 32'h9);

        // 4: press button 3 at T, hold release of button 1 from T+5 (accepted at T+121)
        issue(3, 1'b1);
        for (int c = 0; c <= 2 * (BC + SC) + 2; c++) begin
            @(negedge CLOCK_50_I);
            e    = 4'b0001;
            e[3] = burst_level(1'b1, 1'b0, c);
            e[1] = (c < BC + SC + 1) ? 1'b0 : burst_level(1'b0, 1'b1, c - (BC + SC + 1));
            check($sformatf("b2b_out_c%0d", c),  32'(PUSH_BUTTON_N_O), 32'(e));
            check($sformatf("b2b_done_c%0d", c), 32'(DONE_O),
                  32'(c == BC + SC || c == 2 * (BC + SC) + 1));
            check($sformatf("b2b_busy_c%0d", c), 32'(BUSY_O),
                  32'(c < BC + SC || (c > BC + SC && c < 2 * (BC + SC) + 1)));
            if (c == 5) begin
                cmd_if.CMD_VALID_I  = 1'b1;
                cmd_if.CMD_BUTTON_I = 2'd1;
                cmd_if.CMD_PRESS_I  = 1'b0;
            end
            if (c == BC + SC + 1) cmd_if.CMD_VALID_I = 1'b0;
        end

        // 5: reset mid-bounce aborts immediately with no DONE
        issue(0, 1'b1);
        repeat (50) @(posedge CLOCK_50_I);
        #1 check("mid_busy_before_rst", 32'(BUSY_O), 32'd1);
        #1 RESET_I = 1'b1;
        #1;
        check("abort_out",   32'(PUSH_BUTTON_N_O),    32'hF);
        check("abort_ready", 32'(cmd_if.CMD_READY_O), 32'd1);
        check("abort_busy",  32'(BUSY_O),             32'd0);
        check("abort_done",  32'(DONE_O),             32'd0);
        repeat (2) @(posedge CLOCK_50_I);
        @(negedge CLOCK_50_I);
        RESET_I  = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLOCK_50_I);
            if (DONE_O) done_cnt++;
        end
        check("abort_no_done",  32'(done_cnt),        32'd0);
        check("abort_out_hold", 32'(PUSH_BUTTON_N_O), 32'hF);
        check("abort_idle",     32'(BUSY_O),          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
